// File: rtl/logic_unit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq_pkg
// Brief    : Shared operation and FSM state encodings for logic_unit_seq.
// Revision : 1.0 - initial release
// ============================================================================
package logic_unit_seq_pkg;

    localparam logic [2:0] c_OP_NOT  = 3'b000;
    localparam logic [2:0] c_OP_AND  = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_XNOR = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RUN  = c_ST_RUN,
        ST_DONE = c_ST_DONE
    } state_e;

endpackage : logic_unit_seq_pkg
`default_nettype wire

// File: rtl/logic_unit_seq_slice_logic.sv
`default_nettype none
// ============================================================================
// Module   : slice_logic
// Brief    : Combinational bitwise operation on one SLICE-wide operand slice.
// Revision : 1.0 - initial release
// ============================================================================
module slice_logic
    import logic_unit_seq_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            c_OP_NOT:  y = ~a;
            c_OP_AND:  y = a & b;
            c_OP_OR:   y = a | b;
            c_OP_XOR:  y = a ^ b;
            c_OP_NAND: y = ~(a & b);
            c_OP_NOR:  y = ~(a | b);
            c_OP_XNOR: y = ~(a ^ b);
            c_OP_PASS: y = a;
            default:   y = a;
        endcase
    end

endmodule : slice_logic
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq
// Brief    : Multi-cycle bitwise logic unit processing SLICE bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_seq
    import logic_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_busy,
    output logic             data_isZero
);

    localparam int c_NUM_SLICES = WIDTH / SLICE;
    localparam int c_CNT_W      = (c_NUM_SLICES > 1) ? $clog2(c_NUM_SLICES) : 1;
    localparam int c_IDX_W      = $clog2(WIDTH);

    state_e             r_state_q,  w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [2:0]         r_op_q,     w_op_d;
    logic [WIDTH-1:0]   r_a_q,      w_a_d;
    logic [WIDTH-1:0]   r_b_q,      w_b_d;
    logic [WIDTH-1:0]   r_acc_q,    w_acc_d;
    logic [WIDTH-1:0]   r_result_q, w_result_d;

    logic [c_IDX_W-1:0] w_base;
    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_y_slice;
    logic               w_last;

    // When SLICE == WIDTH the multiplier truncates to 0, which is the only valid base.
    always_comb begin
        w_base    = c_IDX_W'(r_cnt_q) * c_IDX_W'(SLICE);
        w_a_slice = r_a_q[w_base +: SLICE];
        w_b_slice = r_b_q[w_base +: SLICE];
        w_last    = (r_cnt_q == c_CNT_W'(c_NUM_SLICES - 1));
    end

    slice_logic #(
        .SLICE (SLICE)
    ) u_slice_logic (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .op (r_op_q),
        .y  (w_y_slice)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_op_d     = r_op_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_acc_d    = r_acc_q;
        w_result_d = r_result_q;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (ctrl_start) begin
                    w_op_d    = ctrl_op;
                    w_a_d     = data_operandA;
                    w_b_d     = data_operandB;
                    w_cnt_d   = '0;
                    w_state_d = ST_RUN;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_acc_d[w_base +: SLICE] = w_y_slice;
                if (w_last) begin
                    // Result takes the accumulator including the slice written this edge.
                    w_cnt_d    = '0;
                    w_result_d = w_acc_d;
                    w_state_d  = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_op_q     <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_acc_q    <= '0;
            r_result_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_op_q     <= w_op_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_acc_q    <= w_acc_d;
            r_result_q <= w_result_d;
        end
    end

    assign data_result    = r_result_q;
    assign data_resultRDY = (r_state_q == ST_DONE);
    assign data_busy      = (r_state_q == ST_RUN);
    assign data_isZero    = (r_result_q == '0);

endmodule : logic_unit_seq
`default_nettype wire
